rgu_push_arbiter: RTL
=====================

Name: rgu_push_arbiter

Overview:
- Merges the oFifoPush/oFifoData streams of NUM_CORES RayGenerationUnit instances into the single downstream ray FIFO.
- Each core has a small elastic buffer, and buffers are drained round-robin into the shared FIFO.
- Sits between the RGU array and the ray FIFO.
- Stall outputs let the core wrapper gate each RGU's iEnable.

Parameters:
- NUM_CORES, 4, number of RGU requesters (2..8).
- DATA_W, 32, word width; equals GPU_WORD.
- BUF_DEPTH, 4, entries per core buffer (power of 2, ≥2).

Ports:
- iClock  in  1  system clock.
- iReset  in  1  asynchronous, active-low reset.
- iEnable  in  1  arbitration enable; buffers still accept pushes when low.
- iPush  in  NUM_CORES  per-core push strobe (RGU oFifoPush).
- iData  in  NUM_CORES*DATA_W  per-core data; core i at bits [i*DATA_W +: DATA_W].
- oStall  out  NUM_CORES  per-core almost-full; gates that core's iEnable.
- iFifoFull  in  1  downstream FIFO full.
- oFifoPush  out  1  registered push to downstream FIFO.
- oFifoData  out  DATA_W  registered data to downstream FIFO.
- oGrant  out  clog2(NUM_CORES)  index of the core served by the current oFifoPush.
- oOverflow  out  NUM_CORES  sticky flag: push dropped on a full buffer.

Behaviour:
- Reset (iReset=0, async):
  - all buffers empty; round-robin pointer = 0;
  - oFifoPush=0, oFifoData=0, oGrant=0, oStall=0, oOverflow=0.
- Buffer write:
  - iPush[i]=1 at a rising edge writes iData slice i when count[i] < BUF_DEPTH, or when count[i] == BUF_DEPTH and the same edge pops buffer i.
  - Otherwise the word is dropped and oOverflow[i] is set.
  - oOverflow[i] is cleared only by reset.
- Stall:
  - oStall[i] is registered and equals (next count[i] ≥ BUF_DEPTH-1).
  - This leaves one slot for the push already in flight.
- Arbitration, each cycle with iEnable=1, iFifoFull=0 and any buffer non-empty:
  - grant = first non-empty index scanning from ptr upward, modulo NUM_CORES;
  - pop head[grant];
  - at the edge, oFifoPush<=1, oFifoData<=head, oGrant<=grant, ptr<=(grant+1) mod NUM_CORES.
- Otherwise oFifoPush<=0; oFifoData and oGrant hold their values.
- Throughput and latency:
  - 1 word per cycle;
  - push at edge k into an empty buffer with no competition gives oFifoPush high in the cycle after edge k+1 (2 edges).
- Simultaneous push and pop on the same buffer: both occur; count is unchanged.
- iFifoFull is sampled combinationally in the same cycle. While it is high, no pop occurs and the pointer is held.
- iEnable=0 suspends pops only; pushes, stalls and overflow detection continue.
- Fairness: with all cores continuously non-empty, grants cycle 0,1,..,N-1,0,…
- Reset mid-operation discards all buffered words; no partial push is emitted.
- Buffer indices wrap modulo BUF_DEPTH.
- count[i] is clog2(BUF_DEPTH)+1 bits and never exceeds BUF_DEPTH.

Optional Feature:
- Macro: RGU_PUSH_ARB_TAG_EN.
- Defined:
  - adds output oFifoTag, width clog2(NUM_CORES)+8;
  - oFifoTag = {grant, per-core 8-bit sequence number};
  - the sequence number increments, wrapping, on each granted word of that core and resets to 0;
  - the downstream can reorder and trace rays per core.
- Undefined: port and counters absent; all other behaviour is identical.

Decomposition:
- Shared package/definitions file holds:
  - RGU_ARB_CORES_MAX (8);
  - the grant/tag width constants;
  - the RGU_PUSH_ARB_TAG_EN macro definition, next to existing RGU_* defines.
- One sub-module: rgu_push_buffer.
  - Parameterised DATA_W/BUF_DEPTH synchronous FIFO with count, push, pop, head, full/almost-full.
  - Instantiated NUM_CORES times.
  - The arbiter logic stays in the top.

Test Plan:
- Reset then core 2 pushes 32'hA5A50001 once → two edges later oFifoPush=1 for one cycle, oFifoData=32'hA5A50001, oGrant=2; all other outputs stay 0.
- All 4 cores push every cycle, iFifoFull=0:
  - grant sequence is 0,1,2,3,0,… with per-core data order preserved;
  - oStall asserts per core as the buffers fill;
  - pushes gated by oStall cause no overflow.
- iFifoFull=1 for 10 cycles while core 0 pushes 4 words → oStall[0]=1 after the 3rd word, no oFifoPush during the full window; after release the 4 words drain in order, oOverflow=0.
- Core 1 ignores oStall and pushes 6 words with iFifoFull=1 (BUF_DEPTH=4) → oOverflow[1]=1 from the 5th push; the first 4 words drain after release; the flag stays set until reset.
- Assert iReset low with 3 words buffered in core 3 → all outputs return to 0 asynchronously; after release no stale word is emitted.
- With RGU_PUSH_ARB_TAG_EN defined, core 0 sends 257 words → tags {0,8'd0}..{0,8'd255}, then {0,8'd0} (wrap).

Source files
------------

// File: rtl/rgu_push_arbiter_pkg.sv
// Shared constants for the RGU push arbiter. The optional per-core tag output is
// enabled by defining RGU_PUSH_ARB_TAG_EN (kept undefined here; set it on the build line).
package rgu_push_arbiter_pkg;

  localparam int RGU_ARB_CORES_MAX   = 8;
  localparam int RGU_ARB_SEQ_W       = 8;
  localparam int RGU_ARB_GRANT_W_MAX = $clog2(RGU_ARB_CORES_MAX);

  function automatic int rgu_grant_w(input int num_cores);
    return (num_cores > 1) ? $clog2(num_cores) : 1;
  endfunction

  function automatic int rgu_tag_w(input int num_cores);
    return rgu_grant_w(num_cores) + RGU_ARB_SEQ_W;
  endfunction

endpackage

// File: rtl/rgu_push_arbiter_if.sv
// Core-side push streams and downstream FIFO port of the RGU push arbiter.
// oFifoTag exists only when RGU_PUSH_ARB_TAG_EN is defined.
interface rgu_push_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 32
);
  import rgu_push_arbiter_pkg::*;

  localparam int GRANT_W = rgu_grant_w(NUM_CORES);

  logic                        iEnable;
  logic [NUM_CORES-1:0]        iPush;
  logic [NUM_CORES*DATA_W-1:0] iData;
  logic [NUM_CORES-1:0]        oStall;
  logic [NUM_CORES-1:0]        oOverflow;
  logic                        iFifoFull;
  logic                        oFifoPush;
  logic [DATA_W-1:0]           oFifoData;
  logic [GRANT_W-1:0]          oGrant;

`ifdef RGU_PUSH_ARB_TAG_EN
  localparam int TAG_W = rgu_tag_w(NUM_CORES);
  logic [TAG_W-1:0]            oFifoTag;

  modport slave  (input  iEnable, iPush, iData, iFifoFull,
                  output oStall, oOverflow, oFifoPush, oFifoData, oGrant, oFifoTag);
  modport master (output iEnable, iPush, iData, iFifoFull,
                  input  oStall, oOverflow, oFifoPush, oFifoData, oGrant, oFifoTag);
`else
  modport slave  (input  iEnable, iPush, iData, iFifoFull,
                  output oStall, oOverflow, oFifoPush, oFifoData, oGrant);
  modport master (output iEnable, iPush, iData, iFifoFull,
                  input  oStall, oOverflow, oFifoPush, oFifoData, oGrant);
`endif

endinterface

// File: rtl/rgu_push_arbiter_buffer.sv
// Per-core elastic buffer: small synchronous FIFO with registered almost-full
// stall and a sticky overflow flag for pushes dropped while full.
module rgu_push_buffer #(
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_overflow
);

  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] r_mem [BUF_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_stall;
  logic              r_ovf;
  logic              w_full;
  logic              w_rd;
  logic              w_wr;

  assign w_full = (r_count == CNT_W'(BUF_DEPTH));
  assign w_rd   = i_pop && (r_count != '0);
  // A full buffer still accepts a push on the same edge it is popped.
  assign w_wr   = i_push && (!w_full || w_rd);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_wr && w_rd) w_count_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_stall  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_stall <= (w_count_nxt >= CNT_W'(BUF_DEPTH - 1));
      if (i_push && !w_wr) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head        = r_mem[r_rd_ptr];
  assign o_empty       = (r_count == '0);
  assign o_almost_full = r_stall;
  assign o_overflow    = r_ovf;

endmodule

// File: rtl/rgu_push_arbiter.sv
// Round-robin merge of NUM_CORES RGU push streams into one registered FIFO push.
// Define RGU_PUSH_ARB_TAG_EN to add oFifoTag = {grant, per-core sequence number}.
module rgu_push_arbiter
  import rgu_push_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic              iClock,
  input  logic              iReset,
  rgu_push_arbiter_if.slave bus
);

  localparam int GRANT_W = rgu_grant_w(NUM_CORES);
  localparam int SUM_W   = GRANT_W + 1;

  logic [DATA_W-1:0]    w_head [NUM_CORES];
  logic [NUM_CORES-1:0] w_empty;
  logic [NUM_CORES-1:0] w_pop;
  logic [NUM_CORES-1:0] w_stall;
  logic [NUM_CORES-1:0] w_ovf;
  logic [GRANT_W-1:0]   w_grant;
  logic [GRANT_W-1:0]   w_next_ptr;
  logic [SUM_W-1:0]     w_sum;
  logic                 w_found;
  logic                 w_pop_en;

  logic [GRANT_W-1:0]   r_ptr;
  logic                 r_push;
  logic [DATA_W-1:0]    r_data;
  logic [GRANT_W-1:0]   r_grant;

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_buf
    rgu_push_buffer #(
      .DATA_W    (DATA_W),
      .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
      .clk           (iClock),
      .rst_n         (iReset),
      .i_push        (bus.iPush[gi]),
      .i_data        (bus.iData[gi*DATA_W +: DATA_W]),
      .i_pop         (w_pop[gi]),
      .o_head        (w_head[gi]),
      .o_empty       (w_empty[gi]),
      .o_almost_full (w_stall[gi]),
      .o_overflow    (w_ovf[gi])
    );
  end

  // First non-empty buffer at or after the pointer, wrapping modulo NUM_CORES.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_sum = {1'b0, r_ptr} + SUM_W'(k);
      if (w_sum >= SUM_W'(NUM_CORES)) w_sum = w_sum - SUM_W'(NUM_CORES);
      if (!w_found && !w_empty[w_sum[GRANT_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_sum[GRANT_W-1:0];
      end
    end
  end

  assign w_pop_en   = bus.iEnable && !bus.iFifoFull && w_found;
  assign w_pop      = w_pop_en ? (NUM_CORES'(1) << w_grant) : '0;
  assign w_next_ptr = (w_grant == GRANT_W'(NUM_CORES - 1)) ? '0 : w_grant + GRANT_W'(1);

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_ptr   <= '0;
      r_push  <= 1'b0;
      r_data  <= '0;
      r_grant <= '0;
    end else begin
      r_push <= w_pop_en;
      if (w_pop_en) begin
        r_data  <= w_head[w_grant];
        r_grant <= w_grant;
        r_ptr   <= w_next_ptr;
      end
    end
  end

  assign bus.oFifoPush = r_push;
  assign bus.oFifoData = r_data;
  assign bus.oGrant    = r_grant;
  assign bus.oStall    = w_stall;
  assign bus.oOverflow = w_ovf;

`ifdef RGU_PUSH_ARB_TAG_EN
  logic [RGU_ARB_SEQ_W-1:0]         r_seq [NUM_CORES];
  logic [GRANT_W+RGU_ARB_SEQ_W-1:0] r_tag;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      for (int i = 0; i < NUM_CORES; i++) r_seq[i] <= '0;
      r_tag <= '0;
    end else if (w_pop_en) begin
      r_tag          <= {w_grant, r_seq[w_grant]};
      r_seq[w_grant] <= r_seq[w_grant] + RGU_ARB_SEQ_W'(1);
    end
  end

  assign bus.oFifoTag = r_tag;
`endif

endmodule
